frb_threshold_detector: RTL and testbench

- Downstream of the 128-sample moving-average baseline stage in the ROACH2 FRB detection chain.
- Takes a power sample and the baseline aligned with it, and forms the excess (din - avg).
- Flags a candidate burst when the excess exceeds a programmable threshold for MIN_WIDTH consecutive valid samples.
- Emits a one-cycle trigger, then an event report (timestamp, width, peak excess) when the burst ends, followed by a hold-off window.

---
 rtl/frb_threshold_detector_if.sv | 25 ++
 rtl/frb_threshold_detector.sv | 168 ++++++++++++++++
 tb/tb_frb_threshold_detector.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frb_threshold_detector_if.sv
// Sample/threshold inputs and event-report outputs of the FRB threshold detector.
interface frb_threshold_detector_if #(
    parameter int TS_WIDTH  = 32,
    parameter int WID_WIDTH = 16
);
    logic signed [24:0]   din;
    logic signed [24:0]   avg;
    logic                 din_valid;
    logic signed [24:0]   thresh;
    logic                 trigger;
    logic                 event_valid;
    logic [TS_WIDTH-1:0]  event_ts;
    logic [WID_WIDTH-1:0] event_width;
    logic signed [25:0]   event_peak;

    modport master (
        output din, avg, din_valid, thresh,
        input  trigger, event_valid, event_ts, event_width, event_peak
    );

    modport slave (
        input  din, avg, din_valid, thresh,
        output trigger, event_valid, event_ts, event_width, event_peak
    );
endinterface

// File: rtl/frb_threshold_detector.sv
// Excess-over-baseline burst detector: qualifies runs above a frozen
// threshold, pulses a trigger, then reports ts/width/peak and holds off.
module frb_threshold_detector #(
    parameter int MIN_WIDTH   = 4,
    parameter int HOLDOFF_LEN = 16,
    parameter int TS_WIDTH    = 32,
    parameter int WID_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    frb_threshold_detector_if.slave  bus
);
    localparam int RUN_W  = $clog2(MIN_WIDTH + 1);
    localparam int HOLD_W = (HOLDOFF_LEN > 0) ? $clog2(HOLDOFF_LEN + 1) : 1;
    localparam logic [WID_WIDTH-1:0] WMAX = {WID_WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_EVENT, S_HOLDOFF} state_e;

    logic ce_unused;
    assign ce_unused = ce;

    state_e                state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic signed [24:0]    thr_q;
    logic                  s1_valid_q;
    logic                  s1_above_q;
    logic signed [25:0]    s1_diff_q;
    logic [TS_WIDTH-1:0]   s1_ts_q;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [WID_WIDTH-1:0]  width_q, width_d;
    logic signed [25:0]    peak_q, peak_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [TS_WIDTH-1:0]   cts_q, cts_d;
    logic                  trig_q, trig_d;
    logic                  evv_q, evv_d;
    logic [TS_WIDTH-1:0]   ets_q, ets_d;
    logic [WID_WIDTH-1:0]  ew_q, ew_d;
    logic signed [25:0]    ep_q, ep_d;

    logic signed [25:0] diff_w;
    logic signed [25:0] thr_ext;
    logic               above_w;
    logic signed [25:0] peak_max;

    assign diff_w  = {bus.din[24], bus.din} - {bus.avg[24], bus.avg};
    assign thr_ext = {thr_q[24], thr_q};
    assign above_w = diff_w > thr_ext;
    assign peak_max = (s1_diff_q > peak_q) ? s1_diff_q : peak_q;

    // Threshold tracks the input only while idle so a burst sees one value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            thr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_above_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_ts_q    <= '0;
        end else begin
            s1_valid_q <= bus.din_valid;
            if (state_q == S_IDLE) thr_q <= bus.thresh;
            if (bus.din_valid) begin
                s1_diff_q  <= diff_w;
                s1_above_q <= above_w;
                s1_ts_q    <= ts_q;
                ts_q       <= ts_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            width_q <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
            cts_q   <= '0;
            trig_q  <= 1'b0;
            evv_q   <= 1'b0;
            ets_q   <= '0;
            ew_q    <= '0;
            ep_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            width_q <= width_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            cts_q   <= cts_d;
            trig_q  <= trig_d;
            evv_q   <= evv_d;
            ets_q   <= ets_d;
            ew_q    <= ew_d;
            ep_q    <= ep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        width_d = width_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        cts_d   = cts_q;
        trig_d  = 1'b0;
        evv_d   = 1'b0;
        ets_d   = ets_q;
        ew_d    = ew_q;
        ep_d    = ep_q;
        if (s1_valid_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (s1_above_q) begin
                        cts_d  = s1_ts_q;
                        peak_d = s1_diff_q;
                        if (MIN_WIDTH == 1) begin
                            trig_d  = 1'b1;
                            width_d = WID_WIDTH'(1);
                            state_d = S_EVENT;
                        end else begin
                            run_d   = RUN_W'(1);
                            state_d = S_QUALIFY;
                        end
                    end
                end
                S_QUALIFY: begin
                    if (s1_above_q) begin
                        run_d  = run_q + 1'b1;
                        peak_d = peak_max;
                        if (run_d == RUN_W'(MIN_WIDTH)) begin
                            trig_d  = 1'b1;
                            width_d = WID_WIDTH'(MIN_WIDTH);
                            state_d = S_EVENT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EVENT: begin
                    if (s1_above_q) begin
                        if (width_q != WMAX) width_d = width_q + 1'b1;
                        peak_d = peak_max;
                    end else begin
                        evv_d   = 1'b1;
                        ets_d   = cts_q;
                        ew_d    = width_q;
                        ep_d    = peak_q;
                        hold_d  = '0;
                        state_d = (HOLDOFF_LEN == 0) ? S_IDLE : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_d == HOLD_W'(HOLDOFF_LEN)) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.trigger     = trig_q;
    assign bus.event_valid = evv_q;
    assign bus.event_ts    = ets_q;
    assign bus.event_width = ew_q;
    assign bus.event_peak  = ep_q;
endmodule

// File: tb/tb_frb_threshold_detector.sv
// Self-checking bench: table vectors, directed corner sequences and a
// queue-based burst model run against random sample streams.
module tb_frb_threshold_detector;
    localparam int MIN_W = 4;
    localparam int HOLD  = 16;
    localparam logic signed [24:0] AVG  = 25'sh0400000;
    localparam logic signed [24:0] THR  = 25'sh0200000;
    localparam logic signed [24:0] LOW  = 25'sh0400000;
    localparam logic signed [24:0] HIGH = 25'sh0800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frb_threshold_detector_if #(.TS_WIDTH(32), .WID_WIDTH(16)) bus ();
    frb_threshold_detector_if #(.TS_WIDTH(32), .WID_WIDTH(4))  bus4 ();

    assign bus4.din       = bus.din;
    assign bus4.avg       = bus.avg;
    assign bus4.din_valid = bus.din_valid;
    assign bus4.thresh    = bus.thresh;

    frb_threshold_detector #(
        .MIN_WIDTH(MIN_W), .HOLDOFF_LEN(HOLD),
        .TS_WIDTH(32), .WID_WIDTH(16)
    ) u_dut (.clk(clk), .rst(rst), .ce(1'b1), .bus(bus.slave));

    frb_threshold_detector #(
        .MIN_WIDTH(MIN_W), .HOLDOFF_LEN(HOLD),
        .TS_WIDTH(32), .WID_WIDTH(4)
    ) u_dut4 (.clk(clk), .rst(rst), .ce(1'b1), .bus(bus4.slave));

    typedef struct {
        logic               trig;
        logic               ev;
        logic [31:0]        ts;
        logic [15:0]        w;
        logic [3:0]         w4;
        logic signed [25:0] peak;
        logic               tchk;
        logic               tt;
        logic               te;
    } exp_t;

    typedef struct {
        logic signed [24:0] din;
        logic               v;
        logic               et;
        logic               ee;
    } tv_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_trig   = 0;
    int n_trig4  = 0;
    int n_ev     = 0;

    exp_t p1, p2;

    // reference model state: one queue entry per above-threshold sample
    int                 burst[$];
    logic [31:0]        m_ts;
    logic [31:0]        m_bts;
    int                 m_cool;
    logic signed [24:0] m_thr;
    logic [31:0]        m_rts;
    logic [15:0]        m_rw;
    logic [3:0]         m_rw4;
    logic signed [25:0] m_rpk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.trig = 0; e.ev = 0; e.ts = 0; e.w = 0; e.w4 = 0;
        e.peak = 0; e.tchk = 0; e.tt = 0; e.te = 0;
        return e;
    endfunction

    task automatic model_reset();
        burst.delete();
        m_ts = 0; m_bts = 0; m_cool = 0;
        m_rts = 0; m_rw = 0; m_rw4 = 0; m_rpk = 0;
        p1 = zero_exp();
        p2 = zero_exp();
    endtask

    task automatic model(input logic signed [24:0] d,
                         input logic signed [24:0] a, inout exp_t n);
        int df;
        int pk;
        int sz;
        df = int'(d) - int'(a);
        if (m_cool > 0) begin
            m_cool--;
        end else if (df > int'(m_thr)) begin
            if (burst.size() == 0) m_bts = m_ts;
            burst.push_back(df);
            if (burst.size() == MIN_W) n.trig = 1'b1;
        end else begin
            if (burst.size() >= MIN_W) begin
                sz = burst.size();
                pk = burst[0];
                foreach (burst[i]) if (burst[i] > pk) pk = burst[i];
                n.ev   = 1'b1;
                m_rts  = m_bts;
                m_rw   = (sz > 65535) ? 16'hFFFF : 16'(sz);
                m_rw4  = (sz > 15) ? 4'hF : 4'(sz);
                m_rpk  = 26'(pk);
                m_cool = HOLD;
            end
            burst.delete();
        end
        m_ts = m_ts + 1;
    endtask

    task automatic check_out();
        chk("trigger", 64'(bus.trigger), 64'(p2.trig));
        chk("event_valid", 64'(bus.event_valid), 64'(p2.ev));
        chk("event_ts", 64'(bus.event_ts), 64'(p2.ts));
        chk("event_width", 64'(bus.event_width), 64'(p2.w));
        chk("event_peak", 64'(bus.event_peak), 64'(p2.peak));
        chk("trigger_w4", 64'(bus4.trigger), 64'(p2.trig));
        chk("event_valid_w4", 64'(bus4.event_valid), 64'(p2.ev));
        chk("event_width_w4", 64'(bus4.event_width), 64'(p2.w4));
        if (p2.tchk) begin
            chk("tbl_trigger", 64'(bus.trigger), 64'(p2.tt));
            chk("tbl_event", 64'(bus.event_valid), 64'(p2.te));
        end
        if (bus.trigger) n_trig++;
        if (bus4.trigger) n_trig4++;
        if (bus.event_valid) n_ev++;
    endtask

    task automatic step(input logic signed [24:0] d, input logic v,
                        input logic tc = 1'b0, input logic tt = 1'b0,
                        input logic te = 1'b0,
                        input logic signed [24:0] a = AVG);
        exp_t n;
        @(negedge clk);
        check_out();
        p2 = p1;
        bus.din = d;
        bus.avg = a;
        bus.din_valid = v;
        n = zero_exp();
        n.tchk = tc; n.tt = tt; n.te = te;
        if (v) model(d, a, n);
        n.ts = m_rts; n.w = m_rw; n.w4 = m_rw4; n.peak = m_rpk;
        p1 = n;
    endtask

    task automatic run(input logic signed [24:0] d, input int cnt);
        for (int i = 0; i < cnt; i++) step(d, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din_valid = 1'b0;
        #1;
        chk("rst_trigger", 64'(bus.trigger), 64'd0);
        chk("rst_event_valid", 64'(bus.event_valid), 64'd0);
        chk("rst_event_ts", 64'(bus.event_ts), 64'd0);
        chk("rst_event_width", 64'(bus.event_width), 64'd0);
        chk("rst_event_peak", 64'(bus.event_peak), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    tv_t tbl[29];

    initial begin
        int t0, e0;
        logic [31:0] bts;
        for (int i = 0; i < 29; i++) begin
            tbl[i].din = (i >= 3 && i < 9) ? HIGH : LOW;
            tbl[i].v   = 1'b1;
            tbl[i].et  = (i == 6);
            tbl[i].ee  = (i == 9);
        end

        bus.din = '0; bus.avg = '0; bus.din_valid = 1'b0;
        bus.thresh = THR;
        m_thr = THR;
        do_reset();

        // basic trigger from the vector table
        for (int i = 0; i < 29; i++)
            step(tbl[i].din, tbl[i].v, 1'b1, tbl[i].et, tbl[i].ee);
        chk("basic_ts", 64'(bus.event_ts), 64'd3);
        chk("basic_width", 64'(bus.event_width), 64'd6);
        chk("basic_peak", 64'(bus.event_peak), 64'h0400000);

        // short pulse rejected, then a normal burst still qualifies
        t0 = n_trig; e0 = n_ev;
        run(HIGH, 3); run(LOW, 4);
        chk("short_trig", 64'(n_trig - t0), 64'd0);
        chk("short_ev", 64'(n_ev - e0), 64'd0);
        run(HIGH, 5); run(LOW, 20);
        chk("after_short_ev", 64'(n_ev - e0), 64'd1);

        // hold-off: burst 5 valids after report ignored, 17 after reported
        e0 = n_ev;
        run(HIGH, 6); run(LOW, 5); run(HIGH, 6); run(LOW, 20);
        chk("holdoff_ignored", 64'(n_ev - e0), 64'd1);
        e0 = n_ev;
        run(HIGH, 6); run(LOW, 17); run(HIGH, 6); run(LOW, 20);
        chk("holdoff_reported", 64'(n_ev - e0), 64'd2);

        // threshold raised mid-burst has no effect until idle
        e0 = n_ev;
        run(HIGH, 5);
        bus.thresh = 25'sh0FFFFFF;
        run(HIGH, 4); run(LOW, 24);
        chk("freeze_ev", 64'(n_ev - e0), 64'd1);
        chk("freeze_width", 64'(bus.event_width), 64'd9);
        bus.thresh = THR;
        run(LOW, 3);

        // excess exactly equal to threshold is not above
        t0 = n_trig;
        run(AVG + THR, 6); run(LOW, 4);
        chk("equal_no_trig", 64'(n_trig - t0), 64'd0);

        // width saturation with gaps in din_valid
        t0 = n_trig4;
        bts = m_ts;
        for (int i = 0; i < 20; i++) begin
            step(HIGH, 1'b1);
            step(LOW, 1'b0);
        end
        run(LOW, 24);
        chk("sat_w4", 64'(bus4.event_width), 64'd15);
        chk("sat_w16", 64'(bus.event_width), 64'd20);
        chk("sat_single_trig", 64'(n_trig4 - t0), 64'd1);
        chk("sat_ts", 64'(bus4.event_ts), 64'(bts));

        // reset mid-event: no report, timestamps restart at 0
        run(HIGH, 6);
        e0 = n_ev;
        do_reset();
        run(LOW, 2); run(HIGH, 5); run(LOW, 20);
        chk("rst_no_stale_ev", 64'(n_ev - e0), 64'd1);
        chk("rst_new_ts", 64'(bus.event_ts), 64'd2);
        chk("rst_new_width", 64'(bus.event_width), 64'd5);

        // random bursts against the model
        for (int s = 0; s < 80; s++) begin
            int len;
            bit hi;
            len = $urandom_range(1, 9);
            hi  = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < len; k++) begin
                logic signed [24:0] a;
                logic signed [24:0] dl;
                int sel;
                a = 25'($urandom_range(0, 32'h400000));
                sel = $urandom_range(0, 2);
                if (hi)
                    dl = (sel == 0) ? THR + 1 : (sel == 1) ? THR + 25'sh100000
                                                           : 25'sh300000;
                else
                    dl = (sel == 0) ? THR : (sel == 1) ? 25'sh0 : -THR;
                step(a + dl, ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0, a);
            end
        end
        run(LOW, 30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
